// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared types, constants and address helper for the cache fill engine
package cache_pkg;

    localparam int WORDS_PER_BLOCK = 8;
    localparam int BLOCK_OFFSET_W  = 4;
    localparam int ADDR_W          = 16;
    localparam int DATA_W          = 16;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } fill_state_t;

    // Align a byte address down to the start of its cache block.
    function automatic logic [ADDR_W-1:0] block_base(input logic [ADDR_W-1:0] addr);
        return addr & {{(ADDR_W-BLOCK_OFFSET_W){1'b1}}, {BLOCK_OFFSET_W{1'b0}}};
    endfunction

endpackage

// File: rtl/fill_counter.sv
// rtl/fill_counter.sv - up-counter with clear, enable and terminal-count flag
module fill_counter #(
    parameter int WIDTH    = 4,
    parameter int TERMINAL = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] cnt,
    output logic             at_terminal
);

    localparam logic [WIDTH-1:0] TERM_V = WIDTH'(TERMINAL);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // Clear wins over enable so a new fill always starts from zero.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt         = cnt_q;
    assign at_terminal = (cnt_q == TERM_V);

endmodule

// File: rtl/cache_fill_fsm.sv
// rtl/cache_fill_fsm.sv - cache miss block-fill engine driving memory reads and array writes
module cache_fill_fsm #(
    parameter int WORDS_PER_BLOCK = cache_pkg::WORDS_PER_BLOCK,
    parameter int ADDR_W          = cache_pkg::ADDR_W,
    parameter int DATA_W          = cache_pkg::DATA_W
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               miss_detected,
    input  logic [ADDR_W-1:0]                  miss_address,
    input  logic [DATA_W-1:0]                  memory_data,
    input  logic                               memory_data_valid,
    output logic                               fsm_busy,
    output logic                               mem_rd_en,
    output logic [ADDR_W-1:0]                  memory_address,
    output logic                               write_data_array,
    output logic                               write_tag_array,
    output logic [$clog2(WORDS_PER_BLOCK)-1:0] cache_word_idx,
    output logic [DATA_W-1:0]                  cache_data
);

    import cache_pkg::*;

    localparam int OFF_W = $clog2(WORDS_PER_BLOCK * 2);
    localparam int IDX_W = $clog2(WORDS_PER_BLOCK);
    localparam int CNT_W = IDX_W + 1;

    fill_state_t       state_q;
    fill_state_t       state_d;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] base_d;

    logic              start_fill;
    logic              issue_en;
    logic              rcv_en;
    logic [CNT_W-1:0]  issue_cnt;
    logic [CNT_W-1:0]  rcv_cnt;
    logic              issue_done;
    logic              rcv_last;
    logic [OFF_W-1:0]  issue_off;

    // A fill is armed on the edge after a miss is seen in IDLE.
    assign start_fill = (state_q == IDLE) && miss_detected;
    assign issue_en   = (state_q == FILL) && !issue_done;
    assign rcv_en     = (state_q == FILL) && memory_data_valid;

    // Byte offset of the word being requested; carries never leave the offset field.
    assign issue_off  = OFF_W'({issue_cnt, 1'b0});

    fill_counter #(
        .WIDTH    (CNT_W),
        .TERMINAL (WORDS_PER_BLOCK)
    ) u_issue_cnt (
        .clk         (clk),
        .rst         (rst),
        .clr         (start_fill),
        .en          (issue_en),
        .cnt         (issue_cnt),
        .at_terminal (issue_done)
    );

    fill_counter #(
        .WIDTH    (CNT_W),
        .TERMINAL (WORDS_PER_BLOCK - 1)
    ) u_rcv_cnt (
        .clk         (clk),
        .rst         (rst),
        .clr         (start_fill),
        .en          (rcv_en),
        .cnt         (rcv_cnt),
        .at_terminal (rcv_last)
    );

    // State and latched block base; reset abandons any fill in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            base_q  <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
        end
    end

    // Next state: leave IDLE on a miss, return once the last response lands.
    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        case (state_q)
            IDLE: begin
                if (miss_detected) begin
                    state_d = FILL;
                    base_d  = block_base(miss_address);
                end
            end
            FILL: begin
                if (memory_data_valid && rcv_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs: busy is combinational on the miss in IDLE so the stall is immediate.
    always_comb begin
        fsm_busy         = 1'b0;
        mem_rd_en        = 1'b0;
        memory_address   = '0;
        write_data_array = 1'b0;
        write_tag_array  = 1'b0;
        cache_word_idx   = '0;
        cache_data       = '0;
        case (state_q)
            IDLE: begin
                fsm_busy = miss_detected;
            end
            FILL: begin
                fsm_busy = 1'b1;
                if (issue_en) begin
                    mem_rd_en      = 1'b1;
                    memory_address = base_q | {{(ADDR_W-OFF_W){1'b0}}, issue_off};
                end
                if (rcv_en) begin
                    write_data_array = 1'b1;
                    cache_word_idx   = IDX_W'(rcv_cnt);
                    cache_data       = memory_data;
                    write_tag_array  = rcv_last;
                end
            end
            default: begin
                fsm_busy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// tb/tb_cache_fill_fsm.sv - randomized self-checking bench for cache_fill_fsm
module tb_cache_fill_fsm;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        miss_detected = 1'b0;
    logic [15:0] miss_address = '0;
    logic [15:0] memory_data = '0;
    logic        memory_data_valid = 1'b0;
    logic        fsm_busy;
    logic        mem_rd_en;
    logic [15:0] memory_address;
    logic        write_data_array;
    logic        write_tag_array;
    logic [2:0]  cache_word_idx;
    logic [15:0] cache_data;

    int n_vec  = 0;
    int n_fail = 0;
    int resp_t [8];

    cache_fill_fsm dut (
        .clk               (clk),
        .rst               (rst),
        .miss_detected     (miss_detected),
        .miss_address      (miss_address),
        .memory_data       (memory_data),
        .memory_data_valid (memory_data_valid),
        .fsm_busy          (fsm_busy),
        .mem_rd_en         (mem_rd_en),
        .memory_address    (memory_address),
        .write_data_array  (write_data_array),
        .write_tag_array   (write_tag_array),
        .cache_word_idx    (cache_word_idx),
        .cache_data        (cache_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input bit busy, input bit rd, input logic [15:0] addr,
                           input bit wr, input bit tagw, input int idx, input logic [15:0] data);
        chk({tag, ".busy"}, 32'(fsm_busy), 32'(busy));
        chk({tag, ".rd"},   32'(mem_rd_en), 32'(rd));
        chk({tag, ".addr"}, 32'(memory_address), 32'(addr));
        chk({tag, ".wr"},   32'(write_data_array), 32'(wr));
        chk({tag, ".tag"},  32'(write_tag_array), 32'(tagw));
        chk({tag, ".idx"},  32'(cache_word_idx), 32'(idx));
        chk({tag, ".data"}, 32'(cache_data), 32'(data));
    endtask

    // Response k comes at least min_lat cycles after its issue (issue k is on cycle k+1).
    task automatic gen_resp(input int min_lat, input int max_gap);
        int t;
        t = 0;
        for (int k = 0; k < 8; k++) begin
            t = (k == 0) ? (1 + min_lat) : (resp_t[k-1] + 1);
            if (t < k + 1 + min_lat) t = k + 1 + min_lat;
            resp_t[k] = t + int'($urandom_range(max_gap, 0));
        end
    endtask

    // Idle cycles: nothing may move, even with stray memory responses.
    task automatic idle(input int n, input bit stray);
        for (int c = 0; c < n; c++) begin
            miss_detected     = 1'b0;
            miss_address      = 16'($urandom);
            memory_data       = 16'($urandom);
            memory_data_valid = stray ? 1'($urandom) : 1'b0;
            @(negedge clk);
            chk_all("idle", 0, 0, 16'h0, 0, 0, 0, 16'h0);
            @(posedge clk);
            #1;
        end
    endtask

    // One fill starting with the miss on cycle 0; runs through cycle last_cycle
    // (or the final response cycle if last_cycle < 0).
    task automatic fill(input logic [15:0] addr, input bit hold, input logic [15:0] alt_addr,
                        input int last_cycle);
        logic [15:0] base;
        int          stop;
        int          k;
        bit          exp_rd;
        logic [15:0] exp_addr;
        base = addr & 16'hFFF0;
        stop = (last_cycle < 0) ? resp_t[7] : last_cycle;
        for (int c = 0; c <= stop; c++) begin
            k = -1;
            for (int j = 0; j < 8; j++) if (resp_t[j] == c) k = j;
            miss_detected     = (c == 0) || hold;
            miss_address      = (c < 2) ? addr : (hold ? alt_addr : 16'($urandom));
            memory_data       = 16'($urandom);
            memory_data_valid = (k >= 0);
            exp_rd   = (c >= 1) && (c <= 8);
            exp_addr = exp_rd ? base + 16'(2 * (c - 1)) : 16'h0;
            @(negedge clk);
            chk_all("fill", 1, exp_rd, exp_addr, k >= 0, k == 7,
                    (k >= 0) ? k : 0, (k >= 0) ? memory_data : 16'h0);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_all("reset", 0, 0, 16'h0, 0, 0, 0, 16'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        idle(4, 1);

        // Fixed latency 4, no gaps.
        for (int k = 0; k < 8; k++) resp_t[k] = 5 + k;
        fill(16'h1234, 0, 16'h0, -1);
        idle(1, 0);

        // Gapped responses.
        resp_t = '{5, 8, 15, 19, 20, 21, 22, 23};
        fill(16'h0A56, 0, 16'h0, -1);
        idle(2, 0);

        // Miss held with a new address mid-fill, then back-to-back fill of the new block.
        gen_resp(3, 2);
        fill(16'h1234, 1, 16'h5000, -1);
        gen_resp(2, 1);
        fill(16'h5000, 0, 16'h0, -1);
        idle(1, 0);

        // Top-of-memory block must not wrap.
        gen_resp(1, 2);
        fill(16'hFFFF, 0, 16'h0, -1);
        idle(1, 1);

        // Randomized fills with random spacing, including back-to-back.
        for (int i = 0; i < 15; i++) begin
            gen_resp(int'($urandom_range(6, 1)), int'($urandom_range(3, 0)));
            fill(16'($urandom), 0, 16'h0, -1);
            idle(int'($urandom_range(2, 0)), 1);
        end

        // Asynchronous reset after three words received.
        gen_resp(2, 1);
        fill(16'h2222, 0, 16'h0, resp_t[2]);
        miss_detected     = 1'b0;
        memory_data_valid = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        chk_all("async_rst", 0, 0, 16'h0, 0, 0, 0, 16'h0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        idle(5, 1);
        gen_resp(2, 2);
        fill(16'h0040, 0, 16'h0, -1);
        idle(2, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
